tcp_tx_engine: RTL and testbench

- Transmit-side counterpart of the TCP receive datapath. Takes a per-flow send request from the scheduler, reads that flow's TX/RX state and TX payload pointers, and sizes the next segment against the peer window and the MSS.
- Emits a header/payload descriptor toward the packet assembler over a val/rdy handshake, then writes the advanced sequence number back to TX state.
- Sits between the scheduler's data/ack/retransmit-pending flags and the TX header assembler, sharing the flow-state RAMs with the RX path.

---
 rtl/tcp_pkg.sv | 30 +++
 rtl/tcp_tx_engine_if.sv | 58 +++++
 rtl/tcp_tx_seg_calc.sv | 42 ++++
 rtl/tcp_tx_engine.sv | 117 +++++++++++
 tb/tb_tcp_tx_engine.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/tcp_pkg.sv
// Shared constants, descriptor layout and FSM encoding for the TCP transmit engine.
package tcp_pkg;
    localparam int FLOWID_W = 6;
    localparam int TX_PTR_W = 16;
    localparam int MSS      = 1460;

    localparam logic [7:0] TCP_FLAG_FIN = 8'h01;
    localparam logic [7:0] TCP_FLAG_SYN = 8'h02;
    localparam logic [7:0] TCP_FLAG_RST = 8'h04;
    localparam logic [7:0] TCP_FLAG_PSH = 8'h08;
    localparam logic [7:0] TCP_FLAG_ACK = 8'h10;

    typedef struct packed {
        logic [FLOWID_W-1:0] flowid;
        logic [31:0]         seq;
        logic [31:0]         ack;
        logic [7:0]          flags;
        logic [15:0]         win;
        logic [TX_PTR_W-1:0] payload_addr;
        logic [15:0]         payload_len;
    } tx_pkt_desc_struct;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WAIT,
        ST_CALC,
        ST_OUT
    } tx_state_e;
endpackage

// File: rtl/tcp_tx_engine_if.sv
// Scheduler, flow-state RAM and assembler signals of the TX engine; master is the engine side.
interface tcp_tx_engine_if;
    import tcp_pkg::*;

    logic                sched_req_val;
    logic [FLOWID_W-1:0] sched_req_flowid;
    logic                sched_req_rt;
    logic                sched_req_rdy;

    logic                state_rd_req_val;
    logic [FLOWID_W-1:0] state_rd_req_addr;
    logic [31:0]         rd_resp_our_seq;
    logic [31:0]         rd_resp_ack_num;
    logic [15:0]         rd_resp_their_win;
    logic [15:0]         rd_resp_our_win;
    logic [TX_PTR_W:0]   rd_resp_head_ptr;
    logic [TX_PTR_W:0]   rd_resp_tail_ptr;

    logic                seq_wr_req_val;
    logic [FLOWID_W-1:0] seq_wr_req_addr;
    logic [31:0]         seq_wr_req_data;

    logic                tx_pkt_val;
    logic                tx_pkt_rdy;
    logic [FLOWID_W-1:0] tx_pkt_flowid;
    logic [31:0]         tx_pkt_seq_num;
    logic [31:0]         tx_pkt_ack_num;
    logic [7:0]          tx_pkt_flags;
    logic [15:0]         tx_pkt_win;
    logic [TX_PTR_W-1:0] tx_pkt_payload_addr;
    logic [15:0]         tx_pkt_payload_len;

    modport master (
        input  sched_req_val, sched_req_flowid, sched_req_rt,
        output sched_req_rdy,
        output state_rd_req_val, state_rd_req_addr,
        input  rd_resp_our_seq, rd_resp_ack_num, rd_resp_their_win, rd_resp_our_win,
        input  rd_resp_head_ptr, rd_resp_tail_ptr,
        output seq_wr_req_val, seq_wr_req_addr, seq_wr_req_data,
        output tx_pkt_val,
        input  tx_pkt_rdy,
        output tx_pkt_flowid, tx_pkt_seq_num, tx_pkt_ack_num, tx_pkt_flags,
        output tx_pkt_win, tx_pkt_payload_addr, tx_pkt_payload_len
    );

    modport slave (
        output sched_req_val, sched_req_flowid, sched_req_rt,
        input  sched_req_rdy,
        input  state_rd_req_val, state_rd_req_addr,
        output rd_resp_our_seq, rd_resp_ack_num, rd_resp_their_win, rd_resp_our_win,
        output rd_resp_head_ptr, rd_resp_tail_ptr,
        input  seq_wr_req_val, seq_wr_req_addr, seq_wr_req_data,
        input  tx_pkt_val,
        output tx_pkt_rdy,
        input  tx_pkt_flowid, tx_pkt_seq_num, tx_pkt_ack_num, tx_pkt_flags,
        input  tx_pkt_win, tx_pkt_payload_addr, tx_pkt_payload_len
    );
endinterface

// File: rtl/tcp_tx_seg_calc.sv
// Combinational segment sizing: start point, payload length and advanced sequence number.
module tcp_tx_seg_calc
    import tcp_pkg::*;
#(
    parameter int PTR_W   = TX_PTR_W,
    parameter int SEG_MSS = MSS
) (
    input  logic [31:0]  i_our_seq,
    input  logic [PTR_W:0] i_head,
    input  logic [PTR_W:0] i_tail,
    input  logic [15:0]  i_their_win,
    input  logic         i_rt,
    output logic [31:0]  o_start_seq,
    output logic [15:0]  o_len,
    output logic [31:0]  o_new_seq,
    output logic [7:0]   o_flags
);
    localparam int P = PTR_W + 1;

    logic [P-1:0] w_inflight, w_start_ptr, w_avail, w_used, w_win, w_room, w_len;

    // Pointer differences are modulo 2^P so wraps across the extra MSB fall out naturally.
    assign w_inflight  = i_our_seq[PTR_W:0] - i_head;
    assign o_start_seq = i_rt ? i_our_seq - 32'(w_inflight) : i_our_seq;
    assign w_start_ptr = o_start_seq[PTR_W:0];
    assign w_avail     = i_tail - w_start_ptr;
    assign w_used      = i_rt ? '0 : w_inflight;
    assign w_win       = P'(i_their_win);
    assign w_room      = (w_used > w_win) ? '0 : w_win - w_used;

    always_comb begin
        w_len = w_avail;
        if (w_room < w_len)         w_len = w_room;
        if (P'(SEG_MSS) < w_len)    w_len = P'(SEG_MSS);
    end

    assign o_len     = 16'(w_len);
    // A retransmit only advances the sequence if it reaches past what was already sent.
    assign o_new_seq = i_rt ? ((w_len > w_inflight) ? o_start_seq + 32'(w_len) : i_our_seq)
                            : i_our_seq + 32'(w_len);
    assign o_flags   = TCP_FLAG_ACK | ((w_len != '0) ? TCP_FLAG_PSH : 8'h00);
endmodule

// File: rtl/tcp_tx_engine.sv
// Per-flow TX engine: reads flow state, sizes one segment, emits a descriptor, writes back seq.
module tcp_tx_engine
    import tcp_pkg::*;
(
    input logic            clk,
    input logic            rst,
    tcp_tx_engine_if.master bus
);
    tx_state_e         r_state;
    logic              r_rdy, r_rd_val, r_tx_val, r_rt, r_wr_need;
    logic [FLOWID_W-1:0] r_flowid;
    logic [31:0]       r_our_seq, r_ack, r_new_seq;
    logic [15:0]       r_their_win, r_our_win;
    logic [TX_PTR_W:0] r_head, r_tail;
    tx_pkt_desc_struct r_desc;

    logic [31:0] w_start_seq, w_new_seq;
    logic [15:0] w_len;
    logic [7:0]  w_flags;

    tcp_tx_seg_calc #(.PTR_W(TX_PTR_W), .SEG_MSS(MSS)) u_seg_calc (
        .i_our_seq   (r_our_seq),
        .i_head      (r_head),
        .i_tail      (r_tail),
        .i_their_win (r_their_win),
        .i_rt        (r_rt),
        .o_start_seq (w_start_seq),
        .o_len       (w_len),
        .o_new_seq   (w_new_seq),
        .o_flags     (w_flags)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_rdy       <= 1'b0;
            r_rd_val    <= 1'b0;
            r_tx_val    <= 1'b0;
            r_rt        <= 1'b0;
            r_wr_need   <= 1'b0;
            r_flowid    <= '0;
            r_our_seq   <= '0;
            r_ack       <= '0;
            r_new_seq   <= '0;
            r_their_win <= '0;
            r_our_win   <= '0;
            r_head      <= '0;
            r_tail      <= '0;
            r_desc      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_rdy <= 1'b1;
                    if (bus.sched_req_val && r_rdy) begin
                        r_flowid <= bus.sched_req_flowid;
                        r_rt     <= bus.sched_req_rt;
                        r_rdy    <= 1'b0;
                        r_rd_val <= 1'b1;
                        r_state  <= ST_RD;
                    end
                end
                ST_RD: begin
                    r_rd_val <= 1'b0;
                    r_state  <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_our_seq   <= bus.rd_resp_our_seq;
                    r_ack       <= bus.rd_resp_ack_num;
                    r_their_win <= bus.rd_resp_their_win;
                    r_our_win   <= bus.rd_resp_our_win;
                    r_head      <= bus.rd_resp_head_ptr;
                    r_tail      <= bus.rd_resp_tail_ptr;
                    r_state     <= ST_CALC;
                end
                ST_CALC: begin
                    r_desc <= '{flowid:       r_flowid,
                                seq:          w_start_seq,
                                ack:          r_ack,
                                flags:        w_flags,
                                win:          r_our_win,
                                payload_addr: w_start_seq[TX_PTR_W-1:0],
                                payload_len:  w_len};
                    r_new_seq <= w_new_seq;
                    r_wr_need <= (w_new_seq != r_our_seq);
                    r_tx_val  <= 1'b1;
                    r_state   <= ST_OUT;
                end
                ST_OUT: begin
                    if (bus.tx_pkt_rdy) begin
                        r_tx_val <= 1'b0;
                        r_rdy    <= 1'b1;
                        r_state  <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.sched_req_rdy     = r_rdy;
    assign bus.state_rd_req_val  = r_rd_val;
    assign bus.state_rd_req_addr = r_flowid;

    // Write-back strobes in the same cycle the assembler takes the descriptor.
    assign bus.seq_wr_req_val  = r_tx_val && bus.tx_pkt_rdy && r_wr_need;
    assign bus.seq_wr_req_addr = r_desc.flowid;
    assign bus.seq_wr_req_data = r_new_seq;

    assign bus.tx_pkt_val          = r_tx_val;
    assign bus.tx_pkt_flowid       = r_desc.flowid;
    assign bus.tx_pkt_seq_num      = r_desc.seq;
    assign bus.tx_pkt_ack_num      = r_desc.ack;
    assign bus.tx_pkt_flags        = r_desc.flags;
    assign bus.tx_pkt_win          = r_desc.win;
    assign bus.tx_pkt_payload_addr = r_desc.payload_addr;
    assign bus.tx_pkt_payload_len  = r_desc.payload_len;
endmodule

// File: tb/tb_tcp_tx_engine.sv
// Table-driven bench for tcp_tx_engine with a flow-state RAM model and descriptor scoreboard.
module tb_tcp_tx_engine;
    import tcp_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tcp_tx_engine_if bus();
    tcp_tx_engine dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [5:0]  flow;
        logic [31:0] seq;
        logic [31:0] ack;
        logic [15:0] twin;
        logic [15:0] owin;
        logic [16:0] head;
        logic [16:0] tail;
        logic        rt;
        logic [31:0] e_seq;
        logic [15:0] e_len;
        logic [7:0]  e_flags;
        logic [15:0] e_addr;
        logic        e_wr;
        logic [31:0] e_wr_data;
        int          hold;
        logic        busy;
    } vec_t;

    typedef struct {
        logic [5:0]  flow;
        logic [31:0] seq;
        logic [31:0] ack;
        logic [7:0]  flags;
        logic [15:0] win;
        logic [15:0] addr;
        logic [15:0] len;
        logic        wr;
        logic [31:0] wr_data;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0, n_pass = 0, wr_cnt = 0, exp_wr_cnt = 0;

    // Flow-state RAM model: one-cycle read latency, loader port for test setup.
    logic [31:0] m_seq [64], m_ack [64];
    logic [15:0] m_twin[64], m_owin[64];
    logic [16:0] m_head[64], m_tail[64];
    logic        ld_val = 1'b0;
    logic [5:0]  ld_addr;
    vec_t        ld_v;

    always @(posedge clk) begin
        if (bus.state_rd_req_val) begin
            bus.rd_resp_our_seq   <= m_seq [bus.state_rd_req_addr];
            bus.rd_resp_ack_num   <= m_ack [bus.state_rd_req_addr];
            bus.rd_resp_their_win <= m_twin[bus.state_rd_req_addr];
            bus.rd_resp_our_win   <= m_owin[bus.state_rd_req_addr];
            bus.rd_resp_head_ptr  <= m_head[bus.state_rd_req_addr];
            bus.rd_resp_tail_ptr  <= m_tail[bus.state_rd_req_addr];
        end
        if (ld_val) begin
            m_seq[ld_addr]  <= ld_v.seq;  m_ack[ld_addr]  <= ld_v.ack;
            m_twin[ld_addr] <= ld_v.twin; m_owin[ld_addr] <= ld_v.owin;
            m_head[ld_addr] <= ld_v.head; m_tail[ld_addr] <= ld_v.tail;
        end
        if (bus.seq_wr_req_val) begin
            m_seq[bus.seq_wr_req_addr] <= bus.seq_wr_req_data;
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic load(input vec_t v);
        @(negedge clk);
        ld_v = v; ld_addr = v.flow; ld_val = 1'b1;
        @(negedge clk);
        ld_val = 1'b0;
    endtask

    task automatic chk_fields(input exp_t e, input string tag);
        chk({tag, "_flowid"}, 32'(bus.tx_pkt_flowid), 32'(e.flow));
        chk({tag, "_seq"},    bus.tx_pkt_seq_num, e.seq);
        chk({tag, "_ack"},    bus.tx_pkt_ack_num, e.ack);
        chk({tag, "_flags"},  32'(bus.tx_pkt_flags), 32'(e.flags));
        chk({tag, "_win"},    32'(bus.tx_pkt_win), 32'(e.win));
        chk({tag, "_addr"},   32'(bus.tx_pkt_payload_addr), 32'(e.addr));
        chk({tag, "_len"},    32'(bus.tx_pkt_payload_len), 32'(e.len));
    endtask

    task automatic run_req(input logic [5:0] flow, input logic rt, input int hold, input logic busy);
        exp_t e;
        int t;
        t = 0;
        while (!bus.sched_req_rdy && t < 50) begin @(negedge clk); t++; end
        chk("req_rdy", 32'(bus.sched_req_rdy), 32'd1);
        bus.sched_req_val = 1'b1; bus.sched_req_flowid = flow; bus.sched_req_rt = rt;
        @(negedge clk);
        chk("rd_val", 32'(bus.state_rd_req_val), 32'd1);
        chk("rd_addr", 32'(bus.state_rd_req_addr), 32'(flow));
        if (busy) begin
            bus.sched_req_flowid = flow ^ 6'h3f;
            chk("busy_rdy", 32'(bus.sched_req_rdy), 32'd0);
            @(negedge clk); @(negedge clk);
        end
        bus.sched_req_val = 1'b0;
        t = 0;
        while (!bus.tx_pkt_val && t < 20) begin @(negedge clk); t++; end
        chk("tx_val", 32'(bus.tx_pkt_val), 32'd1);
        if (sb.size() == 0) begin
            chk("sb_nonempty", 32'(sb.size()), 32'd1);
            return;
        end
        e = sb.pop_front();
        for (int h = 0; h < hold; h++) begin
            chk_fields(e, "hold");
            chk("hold_val", 32'(bus.tx_pkt_val), 32'd1);
            chk("hold_nowr", 32'(bus.seq_wr_req_val), 32'd0);
            @(negedge clk);
        end
        bus.tx_pkt_rdy = 1'b1;
        #1;
        chk_fields(e, "pkt");
        chk("wr_val", 32'(bus.seq_wr_req_val), 32'(e.wr));
        if (e.wr) begin
            chk("wr_addr", 32'(bus.seq_wr_req_addr), 32'(e.flow));
            chk("wr_data", bus.seq_wr_req_data, e.wr_data);
        end
        @(negedge clk);
        bus.tx_pkt_rdy = 1'b0;
        #1;
        chk("val_drop", 32'(bus.tx_pkt_val), 32'd0);
    endtask

    vec_t vecs[11];

    initial begin
        exp_t e;
        int   t;
        vecs[0]  = '{6'd3,  32'h1000, 32'h1111_1111, 16'hFFFF, 16'h2000, 17'h01000, 17'h01200, 1'b0,
                     32'h1000, 16'h200, 8'h18, 16'h1000, 1'b1, 32'h1200, 0, 1'b0};
        vecs[1]  = '{6'd5,  32'h3000, 32'h2222_2222, 16'hFFFF, 16'h2001, 17'h03000, 17'h04000, 1'b0,
                     32'h3000, 16'd1460, 8'h18, 16'h3000, 1'b1, 32'h35B4, 3, 1'b0};
        vecs[2]  = '{6'd6,  32'h5100, 32'h3333_3333, 16'h0180, 16'h2002, 17'h05000, 17'h06000, 1'b0,
                     32'h5100, 16'h80, 8'h18, 16'h5100, 1'b1, 32'h5180, 0, 1'b1};
        vecs[3]  = '{6'd7,  32'h7000, 32'h0000_ABCD, 16'hFFFF, 16'h2003, 17'h07000, 17'h07000, 1'b0,
                     32'h7000, 16'h0, 8'h10, 16'h7000, 1'b0, 32'h0, 0, 1'b0};
        vecs[4]  = '{6'd8,  32'h2100, 32'h4444_4444, 16'hFFFF, 16'h2004, 17'h02000, 17'h02100, 1'b1,
                     32'h2000, 16'h100, 8'h18, 16'h2000, 1'b0, 32'h0, 0, 1'b0};
        vecs[5]  = '{6'd9,  32'h2100, 32'h5555_5555, 16'hFFFF, 16'h2005, 17'h02000, 17'h02200, 1'b1,
                     32'h2000, 16'h200, 8'h18, 16'h2000, 1'b1, 32'h2200, 0, 1'b0};
        vecs[6]  = '{6'd10, 32'h0001_FFF0, 32'h6666_6666, 16'hFFFF, 16'h2006, 17'h1FFF0, 17'h00010, 1'b0,
                     32'h0001_FFF0, 16'h20, 8'h18, 16'hFFF0, 1'b1, 32'h0002_0010, 0, 1'b0};
        vecs[7]  = '{6'd11, 32'h0100, 32'h7777_7777, 16'h0000, 16'h2007, 17'h00100, 17'h00500, 1'b0,
                     32'h0100, 16'h0, 8'h10, 16'h0100, 1'b0, 32'h0, 0, 1'b0};
        vecs[8]  = '{6'd12, 32'h0400, 32'h8888_8888, 16'h0200, 16'h2008, 17'h00100, 17'h00800, 1'b0,
                     32'h0400, 16'h0, 8'h10, 16'h0400, 1'b0, 32'h0, 0, 1'b0};
        vecs[9]  = '{6'd13, 32'hFFFF_FFF0, 32'h9999_9999, 16'hFFFF, 16'h2009, 17'h1FFF0, 17'h00100, 1'b0,
                     32'hFFFF_FFF0, 16'h110, 8'h18, 16'hFFF0, 1'b1, 32'h0000_0100, 0, 1'b0};
        vecs[10] = '{6'd14, 32'h0002_0010, 32'hAAAA_AAAA, 16'hFFFF, 16'h200A, 17'h1FFF0, 17'h00040, 1'b1,
                     32'h0001_FFF0, 16'h50, 8'h18, 16'hFFF0, 1'b1, 32'h0002_0040, 0, 1'b0};

        rst = 1'b1;
        bus.sched_req_val = 1'b0; bus.sched_req_flowid = '0; bus.sched_req_rt = 1'b0;
        bus.tx_pkt_rdy = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("rst_rdy",    32'(bus.sched_req_rdy), 32'd0);
        chk("rst_txval",  32'(bus.tx_pkt_val), 32'd0);
        chk("rst_rdval",  32'(bus.state_rd_req_val), 32'd0);
        chk("rst_wrval",  32'(bus.seq_wr_req_val), 32'd0);
        chk("rst_seq",    bus.tx_pkt_seq_num, 32'd0);
        chk("rst_len",    32'(bus.tx_pkt_payload_len), 32'd0);
        chk("rst_flags",  32'(bus.tx_pkt_flags), 32'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            load(vecs[i]);
            e = '{vecs[i].flow, vecs[i].e_seq, vecs[i].ack, vecs[i].e_flags, vecs[i].owin,
                  vecs[i].e_addr, vecs[i].e_len, vecs[i].e_wr, vecs[i].e_wr_data};
            if (vecs[i].e_wr) exp_wr_cnt++;
            sb.push_back(e);
            run_req(vecs[i].flow, vecs[i].rt, vecs[i].hold, vecs[i].busy);
        end

        // Flow 3 again: the earlier write-back must be seen, leaving nothing new to send.
        sb.push_back('{6'd3, 32'h1200, 32'h1111_1111, 8'h10, 16'h2000, 16'h1200, 16'h0, 1'b0, 32'h0});
        run_req(6'd3, 1'b0, 0, 1'b0);

        // Reset while a descriptor is pending.
        load('{6'd20, 32'h0100, 32'h0, 16'hFFFF, 16'h0, 17'h00100, 17'h00200, 1'b0,
               32'h0, 16'h0, 8'h0, 16'h0, 1'b0, 32'h0, 0, 1'b0});
        bus.sched_req_val = 1'b1; bus.sched_req_flowid = 6'd20; bus.sched_req_rt = 1'b0;
        @(negedge clk);
        bus.sched_req_val = 1'b0;
        t = 0;
        while (!bus.tx_pkt_val && t < 20) begin @(negedge clk); t++; end
        chk("rst_req_val", 32'(bus.tx_pkt_val), 32'd1);
        bus.tx_pkt_rdy = 1'b1;
        rst = 1'b1;
        #1;
        chk("midrst_val",  32'(bus.tx_pkt_val), 32'd0);
        chk("midrst_wr",   32'(bus.seq_wr_req_val), 32'd0);
        chk("midrst_rdy",  32'(bus.sched_req_rdy), 32'd0);
        @(negedge clk);
        bus.tx_pkt_rdy = 1'b0;
        rst = 1'b0;
        t = 0;
        while (!bus.sched_req_rdy && t < 10) begin @(negedge clk); t++; end
        chk("post_rst_rdy", 32'(bus.sched_req_rdy), 32'd1);
        chk("post_rst_ram", m_seq[20], 32'h0100);

        repeat (3) @(negedge clk);
        chk("wr_count", 32'(wr_cnt), 32'(exp_wr_cnt));
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end
endmodule
